// File: rtl/pmp_access_gate.sv
// pmp_access_gate: single-outstanding gate between a core access port and memory.
// Each request is latched, checked against the PMP (and optional alignment rule),
// forwarded to memory if permitted, and answered with a one-cycle response strobe.
// Optional feature macro: PMP_MISALIGN_CHECK_EN (misaligned half/word faults in CHECK).
//
// state  | meaning
// IDLE   | ready for a new request
// CHECK  | PMP / legality check on the latched request
// ACCESS | memory request outstanding, wait counter running
// RESP   | one-cycle response strobe
module pmp_access_gate #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_oper_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  priv_mode_i,
    output logic [31:0] pmp_addr_o,
    output logic [1:0]  pmp_size_o,
    output logic [1:0]  pmp_oper_o,
    output logic [1:0]  pmp_priv_o,
    input  logic [1:0]  pmp_permission_i,
    output logic        mem_valid_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [1:0]  mem_size_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        resp_valid_o,
    output logic        resp_fault_o,
    output logic [31:0] resp_rdata_o,
    output logic [3:0]  resp_cause_o,
    output logic [31:0] resp_tval_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_FETCH = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;
    localparam logic [1:0] SZ_RSVD  = 2'b11;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  oper_q, size_q, priv_q;
    logic [31:0] addr_q, wdata_q;
    logic [7:0]  cnt_q;
    logic        fault_q;
    logic [3:0]  cause_q;
    logic [31:0] rdata_q, tval_q;

    logic        chk_fault;
    logic [3:0]  chk_cause;
    logic [3:0]  acc_cause;
    logic        timeout_hit;
    logic        unused_perm;

    // Only bit0 of the PMP answer carries meaning.
    assign unused_perm = pmp_permission_i[1];

    // Access-fault cause by operation; reserved oper reports the fetch cause.
    always_comb begin
        case (oper_q)
            OP_LOAD:  acc_cause = 4'd5;
            OP_STORE: acc_cause = 4'd7;
            default:  acc_cause = 4'd1;
        endcase
    end

    // Legality and permission check, evaluated while in CHECK.
    always_comb begin
        chk_fault = 1'b0;
        chk_cause = 4'd0;
        if (oper_q == OP_RSVD) begin
            chk_fault = 1'b1;
            chk_cause = 4'd1;
        end else if (size_q == SZ_RSVD) begin
            chk_fault = 1'b1;
            chk_cause = acc_cause;
`ifdef PMP_MISALIGN_CHECK_EN
        end else if ((size_q == 2'b01 && addr_q[0]) ||
                     (size_q == 2'b10 && addr_q[1:0] != 2'b00)) begin
            chk_fault = 1'b1;
            case (oper_q)
                OP_LOAD:  chk_cause = 4'd4;
                OP_STORE: chk_cause = 4'd6;
                default:  chk_cause = 4'd0;
            endcase
`endif
        end else if (!pmp_permission_i[0]) begin
            chk_fault = 1'b1;
            chk_cause = acc_cause;
        end
    end

    // The last allowed wait cycle; an ack in this same cycle still completes normally.
    assign timeout_hit = (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid_i) state_d = S_CHECK;
            S_CHECK:  state_d = chk_fault ? S_RESP : S_ACCESS;
            S_ACCESS: if (mem_ack_i || timeout_hit) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs; decoded from state_q so reset clears them at once.
    always_comb begin
        req_ready_o  = 1'b0;
        mem_valid_o  = 1'b0;
        mem_we_o     = 1'b0;
        resp_valid_o = 1'b0;
        case (state_q)
            S_IDLE:   req_ready_o = 1'b1;
            S_ACCESS: begin
                mem_valid_o = 1'b1;
                mem_we_o    = (oper_q == OP_STORE);
            end
            S_RESP:   resp_valid_o = 1'b1;
            default:  ;
        endcase
    end

    // Request latch, wait counter and response capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            oper_q  <= 2'b00;
            size_q  <= 2'b00;
            priv_q  <= 2'b00;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
            cause_q <= 4'd0;
            rdata_q <= 32'd0;
            tval_q  <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        oper_q  <= req_oper_i;
                        size_q  <= req_size_i;
                        priv_q  <= priv_mode_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                    end
                end
                S_CHECK: begin
                    cnt_q <= 8'd0;
                    if (chk_fault) begin
                        fault_q <= 1'b1;
                        cause_q <= chk_cause;
                        tval_q  <= addr_q;
                        rdata_q <= 32'd0;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack_i) begin
                        fault_q <= 1'b0;
                        cause_q <= 4'd0;
                        tval_q  <= 32'd0;
                        rdata_q <= (oper_q == OP_STORE) ? 32'd0 : mem_rdata_i;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (timeout_hit) begin
                            fault_q <= 1'b1;
                            cause_q <= acc_cause;
                            tval_q  <= addr_q;
                            rdata_q <= 32'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pmp_addr_o   = addr_q;
    assign pmp_size_o   = size_q;
    assign pmp_oper_o   = oper_q;
    assign pmp_priv_o   = priv_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_size_o   = size_q;
    assign resp_fault_o = fault_q;
    assign resp_cause_o = cause_q;
    assign resp_rdata_o = rdata_q;
    assign resp_tval_o  = tval_q;

endmodule

// File: tb/tb_pmp_access_gate.sv
// Randomized self-checking bench for pmp_access_gate with a transaction-level model.
module tb_pmp_access_gate;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_oper_i, req_size_i, priv_mode_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [31:0] pmp_addr_o;
    logic [1:0]  pmp_size_o, pmp_oper_o, pmp_priv_o;
    logic [1:0]  pmp_permission_i;
    logic        mem_valid_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [1:0]  mem_size_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        resp_valid_o, resp_fault_o;
    logic [31:0] resp_rdata_o, resp_tval_o;
    logic [3:0]  resp_cause_o;

    int checks = 0;
    int errors = 0;

    pmp_access_gate #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_oper_i(req_oper_i), .req_size_i(req_size_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .priv_mode_i(priv_mode_i),
        .pmp_addr_o(pmp_addr_o), .pmp_size_o(pmp_size_o),
        .pmp_oper_o(pmp_oper_o), .pmp_priv_o(pmp_priv_o),
        .pmp_permission_i(pmp_permission_i),
        .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .resp_valid_o(resp_valid_o), .resp_fault_o(resp_fault_o),
        .resp_rdata_o(resp_rdata_o), .resp_cause_o(resp_cause_o),
        .resp_tval_o(resp_tval_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Expected outcome of one transaction from the access rules:
    // fault flag, cause, tval, rdata, response cycle (accept = 0), memory cycles.
    task automatic model(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] ad,
                         input logic [1:0] pm, input int ack_d, input logic [31:0] rd,
                         output logic ef, output logic [3:0] ec, output logic [31:0] et,
                         output logic [31:0] er, output int lat, output int memc);
        logic [3:0] acc;
        logic       pre;
        logic [3:0] pre_c;
        acc   = (op == 2'd0) ? 4'd5 : (op == 2'd1) ? 4'd7 : 4'd1;
        pre   = 1'b0;
        pre_c = 4'd0;
        if (op == 2'd3) begin
            pre = 1'b1; pre_c = 4'd1;
        end else if (sz == 2'd3) begin
            pre = 1'b1; pre_c = acc;
        end
`ifdef PMP_MISALIGN_CHECK_EN
        else if ((sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'd0)) begin
            pre = 1'b1;
            pre_c = (op == 2'd0) ? 4'd4 : (op == 2'd1) ? 4'd6 : 4'd0;
        end
`endif
        else if (!pm[0]) begin
            pre = 1'b1; pre_c = acc;
        end
        if (pre) begin
            ef = 1'b1; ec = pre_c; et = ad; er = 32'd0; lat = 2; memc = 0;
        end else if (ack_d >= 0 && ack_d < TO) begin
            ef = 1'b0; ec = 4'd0; et = 32'd0; er = (op == 2'd1) ? 32'd0 : rd;
            lat = 3 + ack_d; memc = ack_d + 1;
        end else begin
            ef = 1'b1; ec = acc; et = ad; er = 32'd0; lat = 2 + TO; memc = TO;
        end
    endtask

    // Runs one request starting in IDLE (called #1 after a rising edge).
    // ack_d: index of the ACCESS cycle carrying mem_ack; negative means never.
    task automatic run_txn(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] ad,
                           input logic [31:0] wd, input logic [1:0] pv, input logic [1:0] pm,
                           input int ack_d, input logic [31:0] rd);
        logic        ef;
        logic [3:0]  ec;
        logic [31:0] et, er;
        int          lat, memc, mem_cnt;
        bit          done;
        model(op, sz, ad, pm, ack_d, rd, ef, ec, et, er, lat, memc);
        mem_cnt = 0;
        done    = 0;
        check_eq("ready_idle", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1; req_oper_i = op; req_size_i = sz; req_addr_i = ad;
        req_wdata_i = wd; priv_mode_i = pv; pmp_permission_i = pm; mem_ack_i = 1'b0;
        next_cycle();
        req_valid_i = 1'b0; req_oper_i = 2'($urandom); req_size_i = 2'($urandom);
        req_addr_i = $urandom; req_wdata_i = $urandom; priv_mode_i = 2'($urandom);
        check_eq("ready_check", {31'd0, req_ready_o}, 32'd0);
        check_eq("pmp_addr", pmp_addr_o, ad);
        check_eq("pmp_qual", {26'd0, pmp_oper_o, pmp_size_o, pmp_priv_o}, {26'd0, op, sz, pv});
        for (int cyc = 1; cyc <= TO + 6 && !done; cyc++) begin
            mem_ack_i = 1'b0;
            if (cyc >= 2) pmp_permission_i = 2'($urandom);
            if (resp_valid_o) begin
                done = 1;
                check_eq("resp_cycle", cyc, lat);
                check_eq("mem_cycles", mem_cnt, memc);
                check_eq("resp_fault", {31'd0, resp_fault_o}, {31'd0, ef});
                check_eq("resp_cause", {28'd0, resp_cause_o}, {28'd0, ec});
                check_eq("resp_tval", resp_tval_o, et);
                check_eq("resp_rdata", resp_rdata_o, er);
                check_eq("ready_resp", {31'd0, req_ready_o}, 32'd0);
            end else if (mem_valid_o) begin
                check_eq("mem_fields", {29'd0, mem_we_o, mem_size_o}, {29'd0, op == 2'd1, sz});
                check_eq("mem_addr", mem_addr_o, ad);
                check_eq("mem_wdata", mem_wdata_o, wd);
                if (mem_cnt == ack_d) begin
                    mem_ack_i = 1'b1; mem_rdata_i = rd;
                end else begin
                    mem_rdata_i = $urandom;
                end
                mem_cnt++;
            end else begin
                mem_ack_i = 1'($urandom);
                mem_rdata_i = $urandom;
            end
            if (!done) next_cycle();
        end
        if (!done) check_eq("resp_seen", 32'd0, 32'd1);
        mem_ack_i = 1'b0;
        next_cycle();
        check_eq("resp_one_cycle", {31'd0, resp_valid_o}, 32'd0);
        check_eq("ready_after", {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  op, sz, pm;
        logic [31:0] ad;
        int          ad_d;
        bit          seen;
        rst_i = 1'b1; req_valid_i = 1'b0; req_oper_i = 2'd0; req_size_i = 2'd0;
        req_addr_i = 32'd0; req_wdata_i = 32'd0; priv_mode_i = 2'd0;
        pmp_permission_i = 2'd0; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
        next_cycle();
        next_cycle();
        check_eq("rst_ctrl", {27'd0, req_ready_o, mem_valid_o, mem_we_o, resp_valid_o, resp_fault_o},
                 32'b10000);
        check_eq("rst_cause", {28'd0, resp_cause_o}, 32'd0);
        check_eq("rst_tval", resp_tval_o, 32'd0);
        check_eq("rst_rdata", resp_rdata_o, 32'd0);
        check_eq("rst_addr", pmp_addr_o | mem_addr_o | mem_wdata_o, 32'd0);
        rst_i = 1'b0;
        next_cycle();

        // Directed cases.
        run_txn(2'd0, 2'd2, 32'h0000_1000, 32'h0, 2'd1, 2'b01, 0, 32'hDEAD_BEEF);
        run_txn(2'd1, 2'd2, 32'h2000_0004, 32'h1234_5678, 2'd3, 2'b00, 0, 32'h0);
        run_txn(2'd2, 2'd2, 32'h0000_4000, 32'h0, 2'd3, 2'b01, -1, 32'h0);
        run_txn(2'd2, 2'd2, 32'h0000_4000, 32'h0, 2'd3, 2'b01, TO - 1, 32'hCAFE_F00D);
        run_txn(2'd0, 2'd1, 32'h0000_1001, 32'h0, 2'd1, 2'b01, 1, 32'h5555_AAAA);
        run_txn(2'd1, 2'd3, 32'h0000_2000, 32'h0, 2'd1, 2'b01, 0, 32'h0);
        run_txn(2'd3, 2'd2, 32'h0000_3000, 32'h0, 2'd1, 2'b01, 0, 32'h0);
        run_txn(2'd1, 2'd0, 32'h0000_3003, 32'hA5A5_5A5A, 2'd0, 2'b11, 2, 32'hFFFF_FFFF);

        // Reset in the middle of ACCESS, then a normal request.
        req_valid_i = 1'b1; req_oper_i = 2'd0; req_size_i = 2'd2;
        req_addr_i = 32'h0000_8000; pmp_permission_i = 2'b01;
        next_cycle();
        req_valid_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            if (mem_valid_o) seen = 1;
            else next_cycle();
        end
        check_eq("reach_access", {31'd0, seen}, 32'd1);
        next_cycle();
        rst_i = 1'b1;
        #1;
        check_eq("rst_mid", {29'd0, mem_valid_o, req_ready_o, resp_valid_o}, 32'b010);
        next_cycle();
        rst_i = 1'b0;
        next_cycle();
        run_txn(2'd0, 2'd2, 32'h0000_1000, 32'h0, 2'd1, 2'b01, 0, 32'h1357_9BDF);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = $urandom;
            if ($urandom_range(0, 1) == 0) ad[1:0] = 2'b00;
            pm = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'($urandom) | 2'b01;
            ad_d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO + 1));
            run_txn(op, sz, ad, $urandom, 2'($urandom), pm, ad_d, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmp_access_gate.md
PMP_ACCESS_GATE -- requirements
Module: pmp_access_gate

Interface
REQ-001 Parameter: TIMEOUT, 16, maximum cycles waited for mem_ack before a bus fault (range 2..255).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  core access request present.
REQ-005 req_ready  output  1  gate can accept a request.
REQ-006 req_oper  input  2  00 load, 01 store, 10 fetch, 11 reserved.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 req_addr / req_wdata  input  32 each  access address / store data.
REQ-009 priv_mode  input  2  current privilege; sampled with the request.
REQ-010 pmp_addr, pmp_size, pmp_oper, pmp_priv  output  32,2,2,2  query driven to the PMP checker.
REQ-011 pmp_permission  input  2  combinational PMP answer; bit0=1 grant, else deny.
REQ-012 mem_valid, mem_we  output  1,1  memory request, write enable.
REQ-013 mem_addr, mem_wdata, mem_size  output  32,32,2  memory request fields.
REQ-014 mem_ack / mem_rdata  input  1 / 32  memory completion, read data.
REQ-015 resp_valid, resp_fault  output  1,1  one-cycle response strobe, fault flag.
REQ-016 resp_rdata, resp_cause, resp_tval  output  32,4,32  read data, RISC-V cause code, faulting address.

Function
REQ-017 FSM states SHALL be IDLE, CHECK, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 IDLE: req_valid=1 SHALL latch oper, size, addr, wdata, priv_mode and go to CHECK.
REQ-019 pmp_* outputs SHALL be driven from latched fields in every state; PMP result is sampled only in CHECK.
REQ-020 CHECK: reserved oper or size SHALL fault without consulting permission; else permission bit0=1 -> ACCESS, bit0=0 -> RESP with fault.
REQ-021 Access-fault causes SHALL be 1 fetch, 5 load, 7 store; reserved oper SHALL report cause 1 (fetch priority); resp_tval SHALL equal latched address.
REQ-022 ACCESS: mem_valid SHALL stay 1 with stable fields until mem_ack; mem_we=1 only for store.
REQ-023 mem_ack in ACCESS SHALL latch mem_rdata (loads/fetch; 0 for stores) and go to RESP without fault; mem_ack outside ACCESS SHALL be ignored.
REQ-024 Wait counter SHALL clear on ACCESS entry, increment per cycle without ack; reaching TIMEOUT SHALL drop mem_valid next cycle and go to RESP with access fault.
REQ-025 mem_ack in the same cycle the counter reaches TIMEOUT SHALL win (normal completion).
REQ-026 RESP: resp_valid=1 for exactly one cycle, then IDLE; a new request is accepted no earlier than the following cycle.
REQ-027 Minimum latency SHALL be accept(0) -> CHECK(1) -> ACCESS(2) -> RESP(3) with zero-wait mem_ack at cycle 2.
REQ-028 resp_rdata, resp_cause, resp_tval SHALL be 0 whenever resp_fault=0 except resp_rdata.

Reset
REQ-029 reset SHALL force IDLE asynchronously, aborting any in-flight access; mem_valid=0 immediately.
REQ-030 Reset values: req_ready=1, mem_valid=0, mem_we=0, resp_valid=0, resp_fault=0, all data/address/cause outputs and counter 0.

Configuration
REQ-031 Macro PMP_MISALIGN_CHECK_EN defined: in CHECK, half with addr[0]=1 or word with addr[1:0]!=0 SHALL fault before PMP, causes 0 fetch, 4 load, 6 store.
REQ-032 Without PMP_MISALIGN_CHECK_EN: no alignment check; misaligned accesses proceed to PMP and memory unchanged.

Verification
REQ-033 Load word 0x0000_1000, priv 01, permission 01, mem_ack at first ACCESS cycle, rdata 0xDEADBEEF -> resp_valid at cycle 3, fault 0, rdata 0xDEADBEEF.
REQ-034 Store 0x2000_0004, permission 00 -> mem_valid never asserted; resp fault 1, cause 7, tval 0x2000_0004.
REQ-035 Fetch, permission 01, mem_ack never -> mem_valid high TIMEOUT cycles, then resp fault 1, cause 1; mem_ack then ack in cycle TIMEOUT -> no fault.
REQ-036 Load half at 0x0000_1001 -> with PMP_MISALIGN_CHECK_EN cause 4, no mem_valid; without it, memory access issued.
REQ-037 reset asserted mid-ACCESS -> mem_valid 0 and req_ready 1 same cycle; next request completes normally.
REQ-038 req_size=11 with permission 01 -> fault, cause by oper, no mem_valid.
